// File: rtl/fpcvt_pkg.sv
// rtl/fpcvt_pkg.sv - opcode type and IEEE half/single/double format constants for the fpcvt engine
package fpcvt_pkg;

   typedef enum logic [1:0] {
      H2S = 2'b00,
      H2D = 2'b01,
      S2H = 2'b10,
      D2H = 2'b11
   } fpcvt_op_e;

   localparam int H_EXP_W = 5;
   localparam int H_BIAS  = 15;
   localparam int S_EXP_W = 8;
   localparam int S_BIAS  = 127;
   localparam int D_EXP_W = 11;
   localparam int D_BIAS  = 1023;

   localparam int S_BIAS_DELTA = S_BIAS - H_BIAS;
   localparam int D_BIAS_DELTA = D_BIAS - H_BIAS;

   // bit positions inside {invalid, overflow, underflow}
   localparam int FLAG_INVALID   = 2;
   localparam int FLAG_OVERFLOW  = 1;
   localparam int FLAG_UNDERFLOW = 0;

   localparam logic [15:0] H_INF = 16'h7C00;
   localparam logic [31:0] S_INF = 32'h7F80_0000;
   localparam logic [63:0] D_INF = 64'h7FF0_0000_0000_0000;

endpackage

// File: rtl/fpcvt_core.sv
// rtl/fpcvt_core.sv - combinational half<->single/double converter, denormals flushed, truncating
// Build with FPCVT_FLAGS_EN to expose the {invalid, overflow, underflow} flags output.
module fpcvt_core
   import fpcvt_pkg::*;
(
   input  fpcvt_op_e   op,
   input  logic [63:0] operand,
   output logic [63:0] result
`ifdef FPCVT_FLAGS_EN
  ,output logic [2:0]  flags
`endif
);

   logic                 h_sign;
   logic [H_EXP_W-1:0]   h_exp;
   logic [9:0]           h_man;
   logic                 n_sign;
   logic [D_EXP_W-1:0]   n_exp;
   logic [51:0]          n_man;
   logic                 n_exp_max;
   logic signed [12:0]   n_adj;
   logic                 is_wide;
   logic                 wide_zero;
   logic                 wide_max;
   logic                 nar_ovf;
   logic                 nar_unf;

   // narrowing sources are normalised to the double layout with a left-aligned mantissa
   always_comb begin
      h_sign = operand[15];
      h_exp  = operand[14:10];
      h_man  = operand[9:0];
      if (op == S2H) begin
         n_sign    = operand[31];
         n_exp     = D_EXP_W'(operand[30:23]);
         n_man     = {operand[22:0], 29'b0};
         n_exp_max = &operand[30:23];
         n_adj     = 13'(n_exp) - 13'(S_BIAS) + 13'(H_BIAS);
      end else begin
         n_sign    = operand[63];
         n_exp     = operand[62:52];
         n_man     = operand[51:0];
         n_exp_max = &operand[62:52];
         n_adj     = 13'(n_exp) - 13'(D_BIAS) + 13'(H_BIAS);
      end
      is_wide   = (op == H2S) || (op == H2D);
      wide_zero = (h_exp == '0);
      wide_max  = &h_exp;
      nar_ovf   = (n_adj >= 13'sd31);
      nar_unf   = (n_adj <= 13'sd0);
   end

   always_comb begin
      result = '0;
      if (is_wide) begin
         if (wide_zero) begin
            result = (op == H2S) ? {32'b0, h_sign, 31'b0} : {h_sign, 63'b0};
         end else if (wide_max) begin
            result = (op == H2S) ? {32'b0, h_sign, S_INF[30:23], h_man, 13'b0}
                                 : {h_sign, D_INF[62:52], h_man, 42'b0};
         end else begin
            result = (op == H2S) ? {32'b0, h_sign, 8'(h_exp) + 8'(S_BIAS_DELTA), h_man, 13'b0}
                                 : {h_sign, 11'(h_exp) + 11'(D_BIAS_DELTA), h_man, 42'b0};
         end
      end else begin
         if (n_exp_max) begin
            result = {48'b0, n_sign, H_INF[14:10], n_man[51] | (|n_man), n_man[50:42]};
         end else if (nar_ovf) begin
            result = {48'b0, n_sign, H_INF[14:0]};
         end else if (nar_unf) begin
            result = {48'b0, n_sign, 15'b0};
         end else begin
            result = {48'b0, n_sign, n_adj[4:0], n_man[51:42]};
         end
      end
   end

`ifdef FPCVT_FLAGS_EN
   always_comb begin
      flags = '0;
      if (is_wide) begin
         flags[FLAG_UNDERFLOW] = wide_zero && (|h_man);
         flags[FLAG_INVALID]   = wide_max && (|h_man);
      end else begin
         flags[FLAG_INVALID]   = n_exp_max && (|n_man);
         flags[FLAG_OVERFLOW]  = !n_exp_max && nar_ovf;
         flags[FLAG_UNDERFLOW] = !n_exp_max && !nar_ovf && nar_unf && ((|n_exp) || (|n_man));
      end
   end
`endif

endmodule

// File: rtl/fpcvt_arbiter.sv
// rtl/fpcvt_arbiter.sv - round-robin arbiter feeding one shared fpcvt_core through a 2-stage pipeline
// Build with FPCVT_FLAGS_EN to add the registered rsp_flags output.
module fpcvt_arbiter
   import fpcvt_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ-1:0][1:0]  req_op,
   input  logic [N_REQ-1:0][63:0] req_data,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [63:0]            rsp_data
`ifdef FPCVT_FLAGS_EN
  ,output logic [2:0]             rsp_flags
`endif
);

   logic             s1_valid_q, s1_valid_d;
   logic [ID_W-1:0]  s1_id_q, s1_id_d;
   fpcvt_op_e        s1_op_q, s1_op_d;
   logic [63:0]      s1_data_q, s1_data_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
   logic [63:0]      rsp_data_q, rsp_data_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [63:0]      core_result;
   logic             s2_free;
   logic             adv;
   logic             found;
   logic [ID_W-1:0]  gnt_idx;
`ifdef FPCVT_FLAGS_EN
   logic [2:0]       core_flags;
   logic [2:0]       rsp_flags_q, rsp_flags_d;
`endif

   function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int step);
      int sum;
      sum = int'(base) + step;
      if (sum >= N_REQ) sum = sum - N_REQ;
      return ID_W'(sum);
   endfunction

   fpcvt_core u_core (
      .op      (s1_op_q),
      .operand (s1_data_q),
      .result  (core_result)
`ifdef FPCVT_FLAGS_EN
     ,.flags   (core_flags)
`endif
   );

   always_comb begin
      s2_free = !rsp_valid_q || rsp_ready;
      adv     = !s1_valid_q || s2_free;

      found   = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found && req_valid[wrap_idx(rr_ptr_q, k)]) begin
            found   = 1'b1;
            gnt_idx = wrap_idx(rr_ptr_q, k);
         end
      end

      // ready is the grant itself, so every asserted ready is a handshake
      req_ready = '0;
      if (adv && found) req_ready[gnt_idx] = 1'b1;
      rr_ptr_d = (adv && found) ? wrap_idx(gnt_idx, 1) : rr_ptr_q;

      s1_valid_d = s1_valid_q;
      s1_id_d    = s1_id_q;
      s1_op_d    = s1_op_q;
      s1_data_d  = s1_data_q;
      if (adv) begin
         s1_valid_d = found;
         if (found) begin
            s1_id_d   = gnt_idx;
            s1_op_d   = fpcvt_op_e'(req_op[gnt_idx]);
            s1_data_d = req_data[gnt_idx];
         end
      end

      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
`ifdef FPCVT_FLAGS_EN
      rsp_flags_d = rsp_flags_q;
`endif
      if (s2_free) begin
         rsp_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            rsp_id_d   = s1_id_q;
            rsp_data_d = core_result;
`ifdef FPCVT_FLAGS_EN
            rsp_flags_d = core_flags;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q    <= '0;
         s1_valid_q  <= 1'b0;
         s1_id_q     <= '0;
         s1_op_q     <= H2S;
         s1_data_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
`ifdef FPCVT_FLAGS_EN
         rsp_flags_q <= '0;
`endif
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         s1_valid_q  <= s1_valid_d;
         s1_id_q     <= s1_id_d;
         s1_op_q     <= s1_op_d;
         s1_data_q   <= s1_data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
`ifdef FPCVT_FLAGS_EN
         rsp_flags_q <= rsp_flags_d;
`endif
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
`ifdef FPCVT_FLAGS_EN
   assign rsp_flags = rsp_flags_q;
`endif

endmodule

// File: tb/tb_fpcvt_arbiter.sv
// tb/tb_fpcvt_arbiter.sv - self-checking bench for fpcvt_arbiter (flag checks when FPCVT_FLAGS_EN is defined)
module tb_fpcvt_arbiter;

   localparam int N   = 4;
   localparam int IDW = 2;

   logic                clk;
   logic                rst_n;
   logic [N-1:0]        req_valid;
   logic [N-1:0]        req_ready;
   logic [N-1:0][1:0]   req_op;
   logic [N-1:0][63:0]  req_data;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [IDW-1:0]      rsp_id;
   logic [63:0]         rsp_data;
`ifdef FPCVT_FLAGS_EN
   logic [2:0]          rsp_flags;
`endif

   fpcvt_arbiter #(.N_REQ(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_data  (req_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data)
`ifdef FPCVT_FLAGS_EN
     ,.rsp_flags (rsp_flags)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_chk  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // generic IEEE field re-packing; flags ordered {invalid, overflow, underflow}
   function automatic void model(input logic [1:0] op, input logic [63:0] d,
                                 output logic [63:0] res, output logic [2:0] fl);
      int sew, smw, sb, dew, dmw, db;
      bit narrow, sgn;
      longint unsigned sexp, frac, fal, dexp, dfrac, smax, dmax;
      longint e;
      case (op)
         2'b00:   begin sew = 5;  smw = 10; sb = 15;   dew = 8;  dmw = 23; db = 127;  end
         2'b01:   begin sew = 5;  smw = 10; sb = 15;   dew = 11; dmw = 52; db = 1023; end
         2'b10:   begin sew = 8;  smw = 23; sb = 127;  dew = 5;  dmw = 10; db = 15;   end
         default: begin sew = 11; smw = 52; sb = 1023; dew = 5;  dmw = 10; db = 15;   end
      endcase
      narrow = op[1];
      sgn    = d[sew + smw];
      sexp   = (d >> smw) & ((64'd1 << sew) - 1);
      frac   = d & ((64'd1 << smw) - 1);
      fal    = frac << (52 - smw);
      smax   = (64'd1 << sew) - 1;
      dmax   = (64'd1 << dew) - 1;
      fl = 3'b000; dexp = 0; dfrac = 0;
      if (sexp == smax) begin
         dexp  = dmax;
         dfrac = fal >> (52 - dmw);
         if (narrow && frac != 0) dfrac = dfrac | (64'd1 << (dmw - 1));
         fl[2] = (frac != 0);
      end else if (!narrow && sexp == 0) begin
         fl[0] = (frac != 0);
      end else begin
         e = longint'(sexp) - sb + db;
         if (e >= longint'(dmax)) begin
            dexp = dmax; fl[1] = 1'b1;
         end else if (e <= 0) begin
            fl[0] = (sexp != 0 || frac != 0);
         end else begin
            dexp = longint'(e); dfrac = fal >> (52 - dmw);
         end
      end
      res = ({63'b0, sgn} << (dew + dmw)) | (dexp << dmw) | dfrac;
   endfunction

   function automatic logic [63:0] gen_operand(input logic [1:0] op);
      logic [63:0] d;
      d = {$urandom, $urandom};
      case ($urandom_range(0, 4))
         0: case (op)
               2'b00, 2'b01: d[14:10] = 5'h1F;
               2'b10:        d[30:23] = 8'hFF;
               default:      d[62:52] = 11'h7FF;
            endcase
         1: case (op)
               2'b00, 2'b01: d[14:10] = 5'h00;
               2'b10:        d[30:23] = 8'h00;
               default:      d[62:52] = 11'h000;
            endcase
         2: if (op == 2'b10) d[30:23] = 8'(107 + $urandom_range(0, 40));
            else if (op == 2'b11) d[62:52] = 11'(1003 + $urandom_range(0, 40));
         default: ;
      endcase
      if ($urandom_range(0, 7) == 0) d[9:0] = '0;
      if ($urandom_range(0, 7) == 0) d[51:0] = '0;
      return d;
   endfunction

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      int          r;
      logic [1:0]  op;
      logic [63:0] din;
      logic [63:0] dout;
      logic [2:0]  fl;
   } vec_t;

   vec_t vt[14];

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [63:0]    data;
      logic [2:0]     fl;
   } exp_t;

   exp_t        exp_q[$];
   logic [N-1:0] pend;
   int          m_rr;
   logic        prev_stall;
   logic [IDW-1:0] prev_id;
   logic [63:0] prev_data;

   task automatic rnd_cycle(input bit allow_new, input bit force_ready);
      int outstanding, g, idx;
      logic [63:0] r;
      logic [2:0] f;
      exp_t e;
      @(negedge clk);
      if (allow_new) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i]     = 1'b1;
               req_op[i]   = 2'($urandom_range(0, 3));
               req_data[i] = gen_operand(req_op[i]);
            end
         end
      end
      req_valid = pend;
      rsp_ready = force_ready ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      outstanding = exp_q.size();
      if (prev_stall) begin
         check("rnd_hold_valid", rsp_valid, 1);
         check("rnd_hold_id", rsp_id, prev_id);
         check("rnd_hold_data", rsp_data, prev_data);
      end
      check("rnd_spurious", rsp_valid && outstanding == 0, 0);
      check("rnd_onehot", $countones(req_ready) <= 1, 1);
      if (rsp_valid && rsp_ready && outstanding > 0) begin
         e = exp_q.pop_front();
         check("rnd_rsp_id", rsp_id, e.id);
         check("rnd_rsp_data", rsp_data, e.data);
`ifdef FPCVT_FLAGS_EN
         check("rnd_rsp_flags", rsp_flags, e.fl);
`endif
      end
      if (|req_valid && !(rsp_valid && !rsp_ready && outstanding == 2)) begin
         g = -1;
         for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (g < 0 && req_valid[idx]) g = idx;
         end
         check("rnd_grant", req_ready, 64'd1 << g);
         model(req_op[g], req_data[g], r, f);
         exp_q.push_back('{id: IDW'(g), data: r, fl: f});
         m_rr    = (g + 1) % N;
         pend[g] = 1'b0;
      end else begin
         check("rnd_nogrant", req_ready, 0);
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_id    = rsp_id;
      prev_data  = rsp_data;
   endtask

   initial begin
      int rid;
      req_op   = '0;
      req_data = '0;

      vt[0]  = '{0, 2'b00, 64'h3C00,               64'h3F80_0000,           3'b000};
      vt[1]  = '{2, 2'b01, 64'hC000,               64'hC000_0000_0000_0000, 3'b000};
      vt[2]  = '{1, 2'b11, 64'h3FF0_0000_0000_0000, 64'h3C00,               3'b000};
      vt[3]  = '{3, 2'b10, 64'h3F80_0000,          64'h3C00,                3'b000};
      vt[4]  = '{0, 2'b10, 64'h4780_0000,          64'h7C00,                3'b010};
      vt[5]  = '{1, 2'b10, 64'h3300_0000,          64'h0000,                3'b001};
      vt[6]  = '{2, 2'b10, 64'h7FC0_0000,          64'h7E00,                3'b100};
      vt[7]  = '{3, 2'b00, 64'h0001,               64'h0000_0000,           3'b001};
      vt[8]  = '{0, 2'b00, 64'h7C00,               64'h7F80_0000,           3'b000};
      vt[9]  = '{1, 2'b11, 64'hFFF0_0000_0000_0000, 64'hFC00,               3'b000};
      vt[10] = '{2, 2'b01, 64'h7E00,               64'h7FF8_0000_0000_0000, 3'b100};
      vt[11] = '{3, 2'b10, 64'hC780_0000,          64'hFC00,                3'b010};
      vt[12] = '{0, 2'b10, 64'h3880_0000,          64'h0400,                3'b000};
      vt[13] = '{1, 2'b10, 64'h477F_E000,          64'h7BFF,                3'b000};

      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      #1;
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_data", rsp_data, 0);
`ifdef FPCVT_FLAGS_EN
      check("rst_rsp_flags", rsp_flags, 0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (vt[v]) begin
         @(negedge clk);
         req_valid          = '0;
         req_valid[vt[v].r] = 1'b1;
         req_op[vt[v].r]    = vt[v].op;
         req_data[vt[v].r]  = vt[v].din;
         rsp_ready          = 1'b1;
         #1 check("tbl_ready", req_ready, 64'd1 << vt[v].r);
         @(negedge clk);
         req_valid = '0;
         #1 check("tbl_lat_n1", rsp_valid, 0);
         @(negedge clk);
         #1;
         check("tbl_lat_n2", rsp_valid, 1);
         check("tbl_id", rsp_id, vt[v].r);
         check("tbl_data", rsp_data, vt[v].dout);
`ifdef FPCVT_FLAGS_EN
         check("tbl_flags", rsp_flags, vt[v].fl);
`endif
      end

      do_reset();
      req_valid = '1;
      for (int i = 0; i < N; i++) begin
         req_op[i]   = 2'b00;
         req_data[i] = 64'h3C00;
      end
      rsp_ready = 1'b1;
      rid = 0;
      for (int c = 0; c < 12; c++) begin
         #1;
         check("cont_grant", req_ready, 64'd1 << (c % N));
         check("cont_rsp_valid", rsp_valid, c >= 2);
         if (rsp_valid) begin
            check("cont_rsp_id", rsp_id, rid % N);
            check("cont_rsp_data", rsp_data, 64'h3F80_0000);
            rid++;
         end
         @(negedge clk);
      end

      do_reset();
      req_op[1] = 2'b00; req_data[1] = 64'h3C00;
      req_op[2] = 2'b10; req_data[2] = 64'h3F80_0000;
      req_op[3] = 2'b00; req_data[3] = 64'h4000;
      req_valid = 4'b0010;
      #1 check("bp_grant_r1", req_ready, 4'b0010);
      @(negedge clk);
      req_valid = 4'b0100;
      #1 check("bp_grant_r2", req_ready, 4'b0100);
      @(negedge clk);
      req_valid = 4'b1000;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_no_ready", req_ready, 0);
         check("bp_valid", rsp_valid, 1);
         check("bp_id", rsp_id, 1);
         check("bp_data", rsp_data, 64'h3F80_0000);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      #1;
      check("bp_rel_id", rsp_id, 1);
      check("bp_rel_grant_r3", req_ready, 4'b1000);
      @(negedge clk);
      req_valid = '0;
      #1;
      check("bp_second_valid", rsp_valid, 1);
      check("bp_second_id", rsp_id, 2);
      check("bp_second_data", rsp_data, 64'h3C00);
      @(negedge clk);
      #1;
      check("bp_third_id", rsp_id, 3);
      check("bp_third_data", rsp_data, 64'h4000_0000);
      @(negedge clk);
      #1 check("bp_drained", rsp_valid, 0);

      do_reset();
      req_valid = 4'b0001;
      req_op[0] = 2'b00; req_data[0] = 64'h3C00;
      @(negedge clk);
      req_valid = 4'b0010;
      @(negedge clk);
      req_valid = '0;
      #1 check("mid_full", rsp_valid, 1);
      #1 rst_n = 1'b0;
      #1 check("mid_rst_async", rsp_valid, 0);
      @(negedge clk);
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1 check("mid_no_stale", rsp_valid, 0);
         @(negedge clk);
      end
      req_valid = 4'b0110;
      #1 check("mid_first_grant", req_ready, 4'b0010);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      #1 check("mid_first_rsp_id", rsp_id, 1);

      do_reset();
      pend       = '0;
      m_rr       = 0;
      prev_stall = 1'b0;
      exp_q.delete();
      for (int c = 0; c < 2500; c++) rnd_cycle(1'b1, 1'b0);
      for (int c = 0; c < 40; c++) rnd_cycle(1'b0, 1'b1);
      check("rnd_drain_queue", exp_q.size(), 0);
      check("rnd_drain_pend", pend, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
